sync_fifo: RTL and testbench



---
 rtl/sync_fifo_if.sv | 30 +++
 rtl/sync_fifo.sv | 107 ++++++++++
 tb/tb_sync_fifo.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_if.sv
// Handshake and status bundle for sync_fifo: the master drives write/read
// requests, the slave (the FIFO) returns data, occupancy and status flags.
interface sync_fifo_if #(
    parameter int dw    = 32,
    parameter int depth = 16
);
    localparam int cw = $clog2(depth) + 1;

    logic [dw-1:0] din;
    logic          wen;
    logic          ren;
    logic [dw-1:0] dout;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic          almost_empty;
    logic [cw-1:0] count;
    logic          overflow;
    logic          underflow;

    modport master (
        output din, wen, ren,
        input  dout, empty, full, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  din, wen, ren,
        output dout, empty, full, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered status flags, overflow/underflow pulses
// and a choice of registered-read or first-word-fall-through output.
module sync_fifo #(
    parameter int dw     = 32,
    parameter int depth  = 16,
    parameter int af_thr = depth - 2,
    parameter int ae_thr = 2,
    parameter bit fwft   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    sync_fifo_if.slave bus
);
    localparam int aw = $clog2(depth);
    localparam int cw = aw + 1;

    logic [dw-1:0] mem [depth];
    logic [aw-1:0] wptr_reg;
    logic [aw-1:0] rptr_reg;
    logic [aw-1:0] rptr_next;
    logic [cw-1:0] count_reg;
    logic [cw-1:0] count_next;
    logic          empty_reg;
    logic          full_reg;
    logic          af_reg;
    logic          ae_reg;
    logic          ovf_reg;
    logic          unf_reg;
    logic [dw-1:0] dout_reg;
    logic          read_acc;
    logic          write_acc;

    // A write into a full FIFO is still accepted when a read frees a slot in the same cycle.
    always_comb begin
        read_acc   = bus.ren && !empty_reg;
        write_acc  = bus.wen && (!full_reg || read_acc);
        rptr_next  = rptr_reg + aw'(read_acc);
        count_next = count_reg + cw'(write_acc) - cw'(read_acc);
    end

    always_ff @(posedge clk) begin
        if (!rst && write_acc) begin
            mem[wptr_reg] <= bus.din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
            empty_reg <= 1'b1;
            full_reg  <= 1'b0;
            af_reg    <= (af_thr == 0);
            ae_reg    <= 1'b1;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            if (write_acc) begin
                wptr_reg <= wptr_reg + 1'b1;
            end
            rptr_reg  <= rptr_next;
            count_reg <= count_next;
            empty_reg <= (count_next == '0);
            full_reg  <= (count_next == cw'(depth));
            af_reg    <= (count_next >= cw'(af_thr));
            ae_reg    <= (count_next <= cw'(ae_thr));
            ovf_reg   <= bus.wen && !write_acc;
            unf_reg   <= bus.ren && !read_acc;
        end
    end

    generate
        if (fwft) begin : g_fwft
            // Preload the word that will be at the head after this edge; when the
            // FIFO is otherwise drained that word is the one being written now.
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_reg <= '0;
                end else if (count_next != '0) begin
                    if (write_acc && (count_reg == cw'(read_acc))) begin
                        dout_reg <= bus.din;
                    end else begin
                        dout_reg <= mem[rptr_next];
                    end
                end
            end
        end else begin : g_reg_read
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_reg <= '0;
                end else if (read_acc) begin
                    dout_reg <= mem[rptr_reg];
                end
            end
        end
    endgenerate

    assign bus.dout         = dout_reg;
    assign bus.empty        = empty_reg;
    assign bus.full         = full_reg;
    assign bus.almost_full  = af_reg;
    assign bus.almost_empty = ae_reg;
    assign bus.count        = count_reg;
    assign bus.overflow     = ovf_reg;
    assign bus.underflow    = unf_reg;
endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: one registered-read and one fall-through instance share
// stimulus and are checked against a queue-based model plus literal expectations.
module tb_sync_fifo;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sync_fifo_if #(.dw(DW), .depth(DEPTH)) bus0 ();
    sync_fifo_if #(.dw(DW), .depth(DEPTH)) bus1 ();

    sync_fifo #(.dw(DW), .depth(DEPTH), .af_thr(3), .ae_thr(1), .fwft(1'b0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    sync_fifo #(.dw(DW), .depth(DEPTH), .af_thr(3), .ae_thr(1), .fwft(1'b1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    int checks   = 0;
    int failures = 0;
    bit checking = 1'b0;

    // Reference model: contents in order, pending pulses, registered-read output.
    logic [DW-1:0] q[$];
    logic          ovf_m  = 1'b0;
    logic          unf_m  = 1'b0;
    logic [DW-1:0] dout0_m = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic w, input logic r, input logic [DW-1:0] d, input logic rs);
        bit racc;
        bit wacc;
        if (rs) begin
            q.delete();
            ovf_m   = 1'b0;
            unf_m   = 1'b0;
            dout0_m = '0;
        end else begin
            racc  = r && (q.size() > 0);
            wacc  = w && ((q.size() < DEPTH) || racc);
            ovf_m = w && !wacc;
            unf_m = r && !racc;
            if (racc) dout0_m = q.pop_front();
            if (wacc) q.push_back(d);
        end
    endtask

    // Drive one cycle's request, let the edge happen, then advance the model.
    task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d, input logic rs);
        bus0.wen = w; bus0.ren = r; bus0.din = d;
        bus1.wen = w; bus1.ren = r; bus1.din = d;
        rst = rs;
        @(posedge clk);
        #1;
        model_step(w, r, d, rs);
        $display("txn t=%0t rst=%0b wen=%0b ren=%0b din=%02h count=%0d", $time, rs, w, r, d, q.size());
    endtask

    task automatic check_dut(input string tag, input logic [2:0] cnt, input logic e, input logic f,
                             input logic af, input logic ae, input logic ov, input logic un,
                             input logic [DW-1:0] d, input bit fw);
        int n;
        n = q.size();
        chk({tag, ".count"}, 32'(cnt), 32'(n));
        chk({tag, ".empty"}, 32'(e), 32'(n == 0));
        chk({tag, ".full"}, 32'(f), 32'(n == DEPTH));
        chk({tag, ".almost_full"}, 32'(af), 32'(n >= 3));
        chk({tag, ".almost_empty"}, 32'(ae), 32'(n <= 1));
        chk({tag, ".overflow"}, 32'(ov), 32'(ovf_m));
        chk({tag, ".underflow"}, 32'(un), 32'(unf_m));
        if (!fw) chk({tag, ".dout"}, 32'(d), 32'(dout0_m));
        else if (n != 0) chk({tag, ".dout"}, 32'(d), 32'(q[0]));
    endtask

    always @(negedge clk) begin
        if (checking) begin
            check_dut("reg", bus0.count, bus0.empty, bus0.full, bus0.almost_full, bus0.almost_empty,
                      bus0.overflow, bus0.underflow, bus0.dout, 1'b0);
            check_dut("fwft", bus1.count, bus1.empty, bus1.full, bus1.almost_full, bus1.almost_empty,
                      bus1.overflow, bus1.underflow, bus1.dout, 1'b1);
        end
    end

    initial begin
        logic [DW-1:0] wr_vals [4];
        logic [DW-1:0] rd_vals [4];
        int wprob;
        wr_vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        rd_vals = '{8'h22, 8'h33, 8'h44, 8'h66};

        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        checking = 1'b1;
        cycle(1'b1, 1'b1, 8'hEE, 1'b1);
        chk("rst.count", 32'(bus0.count), 0);
        chk("rst.empty", 32'(bus0.empty), 1);
        chk("rst.almost_empty", 32'(bus1.almost_empty), 1);
        chk("rst.almost_full", 32'(bus1.almost_full), 0);
        chk("rst.flags_pulses", {bus0.full, bus0.overflow, bus0.underflow}, 0);
        chk("rst.dout_reg", 32'(bus0.dout), 0);
        chk("rst.dout_fwft", 32'(bus1.dout), 0);

        // Fill to full.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, wr_vals[i], 1'b0);
            chk("fill.count", 32'(bus0.count), 32'(i + 1));
            chk("fill.almost_full", 32'(bus0.almost_full), 32'(i >= 2));
            chk("fill.full", 32'(bus1.full), 32'(i == 3));
            chk("fill.empty", 32'(bus1.empty), 0);
            chk("fill.fwft_head", 32'(bus1.dout), 32'h11);
        end

        // Rejected write while full.
        cycle(1'b1, 1'b0, 8'h55, 1'b0);
        chk("ovf.pulse", 32'(bus0.overflow), 1);
        chk("ovf.count", 32'(bus0.count), 4);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        chk("ovf.clear", 32'(bus0.overflow), 0);

        // Simultaneous read and write while full.
        cycle(1'b1, 1'b1, 8'h66, 1'b0);
        chk("fullrw.count", 32'(bus0.count), 4);
        chk("fullrw.full", 32'(bus1.full), 1);
        chk("fullrw.dout_reg", 32'(bus0.dout), 32'h11);
        for (int i = 0; i < 4; i++) begin
            chk("drain.fwft_head", 32'(bus1.dout), 32'(rd_vals[i]));
            cycle(1'b0, 1'b1, 8'h00, 1'b0);
            chk("drain.dout_reg", 32'(bus0.dout), 32'(rd_vals[i]));
        end
        chk("drain.empty", 32'(bus0.empty), 1);

        // Write and read together on an empty FIFO.
        cycle(1'b1, 1'b1, 8'hA5, 1'b0);
        chk("emptyrw.underflow", 32'(bus0.underflow), 1);
        chk("emptyrw.count", 32'(bus1.count), 1);
        chk("emptyrw.fwft_dout", 32'(bus1.dout), 32'hA5);
        chk("emptyrw.fwft_empty", 32'(bus1.empty), 0);
        chk("emptyrw.dout_hold", 32'(bus0.dout), 32'h66);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        chk("emptyrw.dout_reg", 32'(bus0.dout), 32'hA5);
        chk("emptyrw.unf_clear", 32'(bus0.underflow), 0);

        // Reset mid-operation with a write presented.
        for (int i = 1; i <= 3; i++) cycle(1'b1, 1'b0, 8'(i), 1'b0);
        cycle(1'b1, 1'b0, 8'h99, 1'b1);
        chk("midrst.count", 32'(bus0.count), 0);
        chk("midrst.empty", 32'(bus1.empty), 1);
        chk("midrst.overflow", 32'(bus0.overflow), 0);
        cycle(1'b1, 1'b0, 8'h77, 1'b0);
        chk("midrst.fwft_dout", 32'(bus1.dout), 32'h77);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        chk("midrst.dout_reg", 32'(bus0.dout), 32'h77);

        // Random traffic with phases biased toward filling, draining and balance.
        for (int ph = 0; ph < 4; ph++) begin
            case (ph)
                0: wprob = 75;
                1: wprob = 25;
                2: wprob = 50;
                default: wprob = 90;
            endcase
            for (int c = 0; c < 2500; c++) begin
                cycle(1'($urandom_range(0, 99) < wprob),
                      1'($urandom_range(0, 99) < (100 - wprob + 5)),
                      8'($urandom),
                      1'($urandom_range(0, 999) == 0));
            end
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
